wb_async_mem_arbiter: RTL

- Two-master Wishbone arbiter in front of the single downstream Wishbone slave port.
- Lets the async-memory bridge master (m0) and a second master (m1, debug/DMA) share that port.
- Round-robin grant, held for the whole cyc so multi-beat bursts (e.g. 3x write/read) are never split.
- Watchdog converts a hung slave into a Wishbone error to the requesting master.

---
 rtl/wb_async_mem_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/wb_async_mem_arbiter.sv
// Two-master Wishbone arbiter: round-robin grant held for a whole cycle,
// with a watchdog that turns a hung slave into an error to the granted master.
module wb_async_mem_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, G0, G1} state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic [CW-1:0]   wd_cnt_q, wd_cnt_d;

    logic            g_cyc, g_stb, g_we;
    logic [SW-1:0]   g_sel;
    logic [AW-1:0]   g_adr;
    logic [DW-1:0]   g_dat;
    logic            wd_hit, wd_err;

    // Grant selection; last_q holds the most recently granted master.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    if (last_q) begin
                        state_d = G0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = G1;
                        last_d  = 1'b1;
                    end
                end else if (m0_cyc_i) begin
                    state_d = G0;
                    last_d  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = G1;
                    last_d  = 1'b1;
                end
            end
            G0:      if (!m0_cyc_i) state_d = IDLE;
            G1:      if (!m1_cyc_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Master-to-slave mux driven purely by the registered grant.
    always_comb begin
        g_cyc = 1'b0;
        g_stb = 1'b0;
        g_we  = 1'b0;
        g_sel = '0;
        g_adr = '0;
        g_dat = '0;
        unique case (state_q)
            G0: begin
                g_cyc = m0_cyc_i;
                g_stb = m0_stb_i;
                g_we  = m0_we_i;
                g_sel = m0_sel_i;
                g_adr = m0_adr_i;
                g_dat = m0_dat_i;
            end
            G1: begin
                g_cyc = m1_cyc_i;
                g_stb = m1_stb_i;
                g_we  = m1_we_i;
                g_sel = m1_sel_i;
                g_adr = m1_adr_i;
                g_dat = m1_dat_i;
            end
            default: ;
        endcase
    end

    // Hit is independent of slave response so stb never loops through ack.
    always_comb begin
        wd_hit   = (TIMEOUT != 0) && (state_q != IDLE) && g_stb &&
                   (wd_cnt_q == CW'(TIMEOUT));
        wd_err   = wd_hit && !s_ack_i && !s_err_i;
        wd_cnt_d = '0;
        if ((TIMEOUT != 0) && (state_q != IDLE) && (state_d == state_q) &&
            g_stb && !s_ack_i && !s_err_i && !wd_hit) begin
            wd_cnt_d = wd_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            wd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign s_cyc_o  = g_cyc;
    assign s_stb_o  = g_stb && !wd_hit;
    assign s_we_o   = g_we;
    assign s_sel_o  = g_sel;
    assign s_adr_o  = g_adr;
    assign s_dat_o  = g_dat;

    assign m0_ack_o = (state_q == G0) && s_ack_i;
    assign m0_err_o = (state_q == G0) && (s_err_i || wd_err);
    assign m0_dat_o = (state_q == G0) ? s_dat_i : '0;
    assign m1_ack_o = (state_q == G1) && s_ack_i;
    assign m1_err_o = (state_q == G1) && (s_err_i || wd_err);
    assign m1_dat_o = (state_q == G1) ? s_dat_i : '0;

endmodule
